// File: rtl/tap_seed_controller.sv
// tap_seed_controller
// Drives one seeding cycle of the random module. The sequence is:
//   1. clear the tap selector;
//   2. collect NUM_OF_TAPS nonzero entropy nibbles over a valid/ready handshake
//      and forward each one as a selector take;
//   3. issue the selector's completion take (din = 0);
//   4. wait for sel_done, load the LFSR, then step it WARMUP_CYCLES times;
//   5. report ready.
// A stall of TIMEOUT cycles in COLLECT or WAIT_DONE ends in ERROR.
//
// Ports:
//   clk, res            clock, asynchronous active-high reset
//   start               seeding request (honoured in IDLE/READY/ERROR)
//   rnd_valid/rnd_data  entropy nibble in; rnd_ready = nibble accepted
//   sel_res/sel_take/sel_din, sel_done   tap selector control/status
//   lfsr_load, lfsr_en  LFSR control
//   busy/ready/error    host status; tap_count = nonzero nibbles accepted
//
// State      | meaning
// IDLE       | after reset, waiting for start
// CLEAR      | one-cycle synchronous clear of the selector
// COLLECT    | accepting entropy nibbles, forwarding nonzero ones as takes
// FINALIZE   | last tap take on the wire; completion take issued on exit
// WAIT_DONE  | waiting for the selector to report done
// LOAD       | one-cycle LFSR tap load
// WARMUP     | LFSR stepped for WARMUP_CYCLES cycles
// READY      | LFSR seeded and running
// ERROR      | timeout seen; sticky until the next start
module tap_seed_controller #(
  parameter int NUM_OF_TAPS   = 15,
  parameter int WARMUP_CYCLES = 16,
  parameter int TIMEOUT       = 255
) (
  input  logic       clk,
  input  logic       res,
  input  logic       start,
  input  logic       rnd_valid,
  input  logic [3:0] rnd_data,
  output logic       rnd_ready,
  output logic       sel_res,
  output logic       sel_take,
  output logic [3:0] sel_din,
  input  logic       sel_done,
  output logic       lfsr_load,
  output logic       lfsr_en,
  output logic       busy,
  output logic       ready,
  output logic       error,
  output logic [7:0] tap_count
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int WRM_W = $clog2(WARMUP_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_COLLECT, S_FINALIZE, S_WAIT_DONE,
    S_LOAD, S_WARMUP, S_READY, S_ERROR
  } state_t;

  state_t state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [WRM_W-1:0] wrm_q, wrm_d;
  logic [7:0] tap_count_q, tap_count_d;
  logic       rnd_ready_q, rnd_ready_d;
  logic       sel_res_q, sel_res_d;
  logic       sel_take_q, sel_take_d;
  logic [3:0] sel_din_q, sel_din_d;
  logic       lfsr_load_q, lfsr_load_d;
  logic       lfsr_en_q, lfsr_en_d;
  logic       busy_q, busy_d;
  logic       ready_q, ready_d;
  logic       error_q, error_d;
  logic       hs;

  // rnd_ready_q is only ever high in COLLECT, so this is the handshake.
  assign hs = rnd_valid && rnd_ready_q;

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    wrm_d       = wrm_q;
    tap_count_d = tap_count_q;
    sel_take_d  = 1'b0;
    sel_din_d   = 4'h0;

    case (state_q)
      S_IDLE, S_READY, S_ERROR: begin
        if (start) begin
          state_d     = S_CLEAR;
          tap_count_d = 8'd0;
        end
      end
      S_CLEAR: begin
        state_d = S_COLLECT;
        tmo_d   = '0;
      end
      S_COLLECT: begin
        if (hs) begin
          tmo_d = '0;
          // Zero nibbles are consumed but never become taps.
          if (rnd_data != 4'h0) begin
            sel_take_d  = 1'b1;
            sel_din_d   = rnd_data;
            tap_count_d = tap_count_q + 8'd1;
            if (tap_count_q == 8'(NUM_OF_TAPS - 1)) state_d = S_FINALIZE;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d = S_ERROR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_FINALIZE: begin
        // Completion take: din = 0 tells the selector the set is complete.
        sel_take_d = 1'b1;
        state_d    = S_WAIT_DONE;
        tmo_d      = '0;
      end
      S_WAIT_DONE: begin
        if (sel_done) begin
          state_d = S_LOAD;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d = S_ERROR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_LOAD: begin
        state_d = S_WARMUP;
        wrm_d   = WRM_W'(WARMUP_CYCLES - 1);
      end
      S_WARMUP: begin
        if (wrm_q == '0) state_d = S_READY;
        else             wrm_d   = wrm_q - WRM_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    rnd_ready_d = (state_d == S_COLLECT);
    sel_res_d   = (state_d == S_CLEAR);
    lfsr_load_d = (state_d == S_LOAD);
    lfsr_en_d   = (state_d == S_WARMUP) || (state_d == S_READY);
    ready_d     = (state_d == S_READY);
    error_d     = (state_d == S_ERROR);
    busy_d      = state_d inside {S_CLEAR, S_COLLECT, S_FINALIZE,
                                  S_WAIT_DONE, S_LOAD, S_WARMUP};
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= S_IDLE;
      tmo_q       <= '0;
      wrm_q       <= '0;
      tap_count_q <= 8'd0;
      rnd_ready_q <= 1'b0;
      sel_res_q   <= 1'b0;
      sel_take_q  <= 1'b0;
      sel_din_q   <= 4'h0;
      lfsr_load_q <= 1'b0;
      lfsr_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      wrm_q       <= wrm_d;
      tap_count_q <= tap_count_d;
      rnd_ready_q <= rnd_ready_d;
      sel_res_q   <= sel_res_d;
      sel_take_q  <= sel_take_d;
      sel_din_q   <= sel_din_d;
      lfsr_load_q <= lfsr_load_d;
      lfsr_en_q   <= lfsr_en_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
    end
  end

  assign rnd_ready = rnd_ready_q;
  assign sel_res   = sel_res_q;
  assign sel_take  = sel_take_q;
  assign sel_din   = sel_din_q;
  assign lfsr_load = lfsr_load_q;
  assign lfsr_en   = lfsr_en_q;
  assign busy      = busy_q;
  assign ready     = ready_q;
  assign error     = error_q;
  assign tap_count = tap_count_q;

endmodule

// File: tb/tb_tap_seed_controller.sv
module tb_tap_seed_controller;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       start = 1'b0;
  logic       rnd_valid = 1'b0;
  logic [3:0] rnd_data = 4'h0;
  logic       rnd_ready;
  logic       sel_res, sel_take;
  logic [3:0] sel_din;
  logic       sel_done;
  logic       lfsr_load, lfsr_en, busy, ready, error;
  logic [7:0] tap_count;

  tap_seed_controller #(.NUM_OF_TAPS(3), .WARMUP_CYCLES(4), .TIMEOUT(8)) dut (
    .clk(clk), .res(res), .start(start),
    .rnd_valid(rnd_valid), .rnd_data(rnd_data), .rnd_ready(rnd_ready),
    .sel_res(sel_res), .sel_take(sel_take), .sel_din(sel_din), .sel_done(sel_done),
    .lfsr_load(lfsr_load), .lfsr_en(lfsr_en),
    .busy(busy), .ready(ready), .error(error), .tap_count(tap_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int src[$];
  int exp_q[$];
  int last_hs_cyc = 0;
  int comp_cyc = 0;
  int load_cnt = 0;
  int en_cnt = 0;
  int overlap = 0;
  int mon_e;
  logic hs_pending = 1'b0;
  logic block_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Selector model: registers done one cycle after the completion take.
  always @(posedge clk or posedge res) begin
    if (res)                                              sel_done <= 1'b0;
    else if (sel_res)                                     sel_done <= 1'b0;
    else if (sel_take && sel_din == 4'h0 && !block_done)  sel_done <= 1'b1;
  end

  // Entropy source: presents the head of src; pops after a handshake edge.
  always @(negedge clk) begin
    if (hs_pending && src.size() > 0) begin
      src.delete(0);
      last_hs_cyc = cyc;
    end
    if (src.size() > 0) begin
      rnd_valid = 1'b1;
      rnd_data  = 4'(src[0]);
    end else begin
      rnd_valid = 1'b0;
      rnd_data  = 4'h0;
    end
    hs_pending = rnd_valid && rnd_ready && !res;
  end

  // Scoreboard monitor: every take must match the next expected nibble.
  always @(negedge clk) begin
    if (!res) begin
      if (sel_take) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL take_unexpected: got sel_din=%0d, no take expected", sel_din);
        end else begin
          mon_e = exp_q.pop_front();
          check("take_din", 32'(sel_din), 32'(mon_e));
        end
        if (sel_din == 4'h0) comp_cyc = cyc;
      end
      if (lfsr_load) load_cnt++;
      if (lfsr_en && !ready) en_cnt++;
      if (lfsr_load && lfsr_en) overlap++;
    end
  end

  task automatic pulse_start(output int t0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_ready(input string tag, output int t);
    t = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready) begin t = cyc; break; end
    end
    if (t < 0) begin
      checks++; errors++;
      $display("FAIL %s: got no ready within 200 cycles, required ready=1", tag);
      t = cyc;
    end
  endtask

  task automatic wait_error(input string tag, output int t);
    t = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (error) begin t = cyc; break; end
    end
    if (t < 0) begin
      checks++; errors++;
      $display("FAIL %s: got no error within 200 cycles, required error=1", tag);
      t = cyc;
    end
  endtask

  int t0, t1;
  int found;

  initial begin
    // Reset state
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_error", 32'(error), 0);
    check("rst_rnd_ready", 32'(rnd_ready), 0);
    check("rst_tap_count", 32'(tap_count), 0);
    check("rst_lfsr_en", 32'(lfsr_en), 0);
    repeat (2) @(negedge clk);
    res = 1'b0;

    // 1: basic run
    load_cnt = 0; en_cnt = 0;
    src = '{5, 9, 15};
    exp_q = '{5, 9, 15, 0};
    pulse_start(t0);
    check("t1_clear_sel_res", 32'(sel_res), 1);
    check("t1_clear_busy", 32'(busy), 1);
    wait_ready("t1_ready_wait", t1);
    check("t1_latency", 32'(t1 - t0), 12);
    check("t1_load_cycles", 32'(load_cnt), 1);
    check("t1_warmup_cycles", 32'(en_cnt), 4);
    check("t1_tap_count", 32'(tap_count), 3);
    check("t1_takes_left", 32'(exp_q.size()), 0);
    check("t1_busy", 32'(busy), 0);

    // 2: zero nibbles discarded
    src = '{0, 7, 0, 0, 3, 12, 4};
    exp_q = '{7, 3, 12, 0};
    pulse_start(t0);
    wait_ready("t2_ready_wait", t1);
    check("t2_latency", 32'(t1 - t0), 15);
    check("t2_tap_count", 32'(tap_count), 3);
    check("t2_src_left", 32'(src.size()), 1);
    check("t2_rnd_ready", 32'(rnd_ready), 0);
    check("t2_takes_left", 32'(exp_q.size()), 0);
    src.delete();

    // 3: COLLECT stall timeout
    load_cnt = 0;
    src = '{6};
    exp_q = '{6};
    pulse_start(t0);
    wait_error("t3_error_wait", t1);
    check("t3_idle_cycles", 32'(t1 - last_hs_cyc), 8);
    check("t3_busy", 32'(busy), 0);
    check("t3_rnd_ready", 32'(rnd_ready), 0);
    check("t3_lfsr_en", 32'(lfsr_en), 0);
    check("t3_load_never", 32'(load_cnt), 0);
    check("t3_tap_count", 32'(tap_count), 1);
    check("t3_takes_left", 32'(exp_q.size()), 0);
    src = '{1, 2, 3};
    exp_q = '{1, 2, 3, 0};
    pulse_start(t0);
    check("t3_error_cleared", 32'(error), 0);
    check("t3_sel_res", 32'(sel_res), 1);
    @(negedge clk);
    check("t3_sel_res_pulse", 32'(sel_res), 0);
    wait_ready("t3_ready_wait", t1);
    check("t3_recover_tap_count", 32'(tap_count), 3);

    // 4: WAIT_DONE timeout
    load_cnt = 0;
    block_done = 1'b1;
    src = '{2, 4, 8};
    exp_q = '{2, 4, 8, 0};
    pulse_start(t0);
    wait_error("t4_error_wait", t1);
    check("t4_wait_cycles", 32'(t1 - comp_cyc), 8);
    check("t4_load_never", 32'(load_cnt), 0);
    check("t4_tap_count", 32'(tap_count), 3);
    check("t4_takes_left", 32'(exp_q.size()), 0);
    block_done = 1'b0;

    // 5: start ignored in COLLECT, honoured in READY
    src = '{3, 0, 0, 5, 0, 7};
    exp_q = '{3, 5, 7, 0};
    pulse_start(t0);
    @(negedge clk); start = 1'b1;
    check("t5_in_collect", 32'(rnd_ready), 1);
    @(negedge clk); start = 1'b0;
    wait_ready("t5_ready_wait", t1);
    check("t5_latency", 32'(t1 - t0), 15);
    check("t5_tap_count", 32'(tap_count), 3);
    src = '{8, 8, 8};
    exp_q = '{8, 8, 8, 0};
    pulse_start(t0);
    check("t5_ready_drop", 32'(ready), 0);
    check("t5_sel_res", 32'(sel_res), 1);
    check("t5_busy", 32'(busy), 1);
    wait_ready("t5_reseed_wait", t1);
    check("t5_reseed_latency", 32'(t1 - t0), 12);
    check("t5_takes_left", 32'(exp_q.size()), 0);

    // 6: asynchronous reset during WARMUP
    src = '{1, 2, 3};
    exp_q = '{1, 2, 3, 0};
    pulse_start(t0);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (lfsr_en && !ready) begin found = 1; break; end
    end
    check("t6_reached_warmup", 32'(found), 1);
    @(negedge clk);
    #2 res = 1'b1;
    #1;
    check("t6_async_lfsr_en", 32'(lfsr_en), 0);
    check("t6_async_busy", 32'(busy), 0);
    check("t6_async_tap_count", 32'(tap_count), 0);
    @(negedge clk);
    res = 1'b0;
    src.delete();
    exp_q.delete();
    src = '{4, 5, 6};
    exp_q = '{4, 5, 6, 0};
    pulse_start(t0);
    wait_ready("t6_ready_wait", t1);
    check("t6_latency", 32'(t1 - t0), 12);
    check("t6_tap_count", 32'(tap_count), 3);
    check("t6_takes_left", 32'(exp_q.size()), 0);

    check("load_en_overlap", 32'(overlap), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tap_seed_controller.md
# tap_seed_controller

Sequencer that drives one tap-selection (seeding) cycle of the random module. On a `start` pulse it clears the selector, draws nonzero 4-bit tap nibbles from the entropy source over a valid/ready handshake, and issues the selector's `take` pulses, including the final take that completes it. It then loads the LFSR with the new taps and warms it up. It also reports busy/ready/error status to the host. It sits between the entropy source, the tap selector and the LFSR core.

## Interface
- `NUM_OF_TAPS`, 15: nibbles collected per seeding; must match the selector.
- `WARMUP_CYCLES`, 16: LFSR enable cycles after load before `ready`; ≥1.
- `TIMEOUT`, 255: max consecutive cycles without progress in COLLECT/WAIT_DONE; ≥1.
- `clk`  in  1  clock, all state on rising edge.
- `res`  in  1  reset, asynchronous, active-high.
- `start`  in  1  seeding request; honoured only in IDLE, READY, ERROR.
- `rnd_valid`  in  1  entropy nibble valid.
- `rnd_data`  in  4  entropy nibble.
- `rnd_ready`  out  1  controller accepts nibble.
- `sel_res`  out  1  synchronous clear to selector.
- `sel_take`  out  1  take strobe to selector.
- `sel_din`  out  4  tap nibble to selector.
- `sel_done`  in  1  selector finished.
- `lfsr_load`  out  1  load taps into LFSR.
- `lfsr_en`  out  1  LFSR step enable.
- `busy`  out  1  seeding in progress.
- `ready`  out  1  LFSR seeded and running.
- `error`  out  1  timeout occurred; sticky until next `start`.
- `tap_count`  out  8  nibbles accepted this seeding.

## Operation
- All outputs registered. On `res`, state = IDLE and every output is 0. Internal counters are also 0.
- In IDLE, `start` moves the FSM to CLEAR.
- In CLEAR, `sel_res`=1 and `busy`=1. `tap_count` is cleared. Next state is COLLECT.
- In COLLECT, `rnd_ready`=1.
  - A handshake occurs when `rnd_valid`&`rnd_ready` at a clock edge.
  - A nonzero nibble sets `sel_take`=1 and `sel_din`=nibble for the next cycle and increments `tap_count`.
  - A zero nibble is consumed and discarded: no take, no count change.
  - After the `NUM_OF_TAPS`-th nonzero accept, the FSM goes to FINALIZE.
- FINALIZE lasts 1 cycle. On its exit edge the controller issues one extra take with `sel_take`=1 and `sel_din`=0. This is the selector's completion take. Next state is WAIT_DONE.
- In WAIT_DONE, `sel_done`=1 moves the FSM to LOAD.
- LOAD lasts 1 cycle with `lfsr_load`=1. Next state is WARMUP.
- WARMUP holds `lfsr_en`=1 for exactly `WARMUP_CYCLES` cycles, then goes to READY.
- In READY, `ready`=1 and `lfsr_en`=1. `start` moves the FSM to CLEAR (reseed); `ready` drops.
- Timeout:
  - A counter is cleared on entry to COLLECT, on each handshake, and on entry to WAIT_DONE.
  - It increments on every other cycle spent in COLLECT or WAIT_DONE.
  - When it reaches `TIMEOUT`, the FSM goes to ERROR.
- In ERROR, `error`=1 and all strobes are 0. `start` moves the FSM to CLEAR and clears `error` on that edge.
- `busy`=1 in CLEAR through WARMUP inclusive. `start` in busy states is ignored.
- `tap_count` holds its value through READY/ERROR until the next CLEAR.

## Timing
- `start` at edge n → CLEAR during cycle n+1 (`sel_res` high) → COLLECT from n+2.
- Handshake at edge k → `sel_take` high during cycle k+1 only. Back-to-back handshakes give back-to-back takes.
- The last nonzero handshake drops `rnd_ready` in the following cycle, which is FINALIZE. In that cycle `sel_take` carries the last nibble.
- The completion take is high in the first WAIT_DONE cycle. With a selector that registers `done`, `sel_done` rises one cycle later. LOAD follows on the next edge.
- `lfsr_load` and `lfsr_en` are never high in the same cycle.
- Minimum start→ready latency with a continuously valid nonzero source: 1 (CLEAR) + `NUM_OF_TAPS` (COLLECT) + 1 (FINALIZE) + 2 (WAIT_DONE) + 1 (LOAD) + `WARMUP_CYCLES`. With defaults: 1+15+1+2+1+16 = 36 cycles.
- `res` asserted mid-operation: all outputs 0 immediately (asynchronous), state IDLE. The selector is cleared by the next CLEAR.

## Test plan
1. Bench parameters `NUM_OF_TAPS`=3, `WARMUP_CYCLES`=4, `TIMEOUT`=8. Source always valid with nibbles 5, 9, 15; `start` pulse. Required:
   - takes carry 5, 9, 15, then 0;
   - `lfsr_load` for 1 cycle, then `lfsr_en` for 4 cycles;
   - `ready` rises 12 cycles after `start`;
   - `tap_count`=3.
2. Source 0, 7, 0, 0, 3, 12 → takes carry 7, 3, 12 only; `tap_count`=3; `rnd_ready` low after nibble 12.
3. Source stalls after 1 nonzero nibble → `error`=1 exactly 8 idle cycles after the last handshake, with `busy`=0, `rnd_ready`=0 and `lfsr_load` never asserted. A following `start` clears `error` and `sel_res` pulses.
4. `sel_done` held low by the bench → WAIT_DONE timeout to ERROR after 8 cycles.
5. `start` pulses during COLLECT → ignored, sequence unchanged. `start` in READY → `ready`=0 next cycle, `sel_res` pulse, full reseed.
6. `res` asserted in the middle of WARMUP → `lfsr_en`, `busy` and `tap_count` go to 0 without a clock edge. Release then `start` → normal run completes.
